trace_serializer: RTL and testbench

TRACE_SERIALIZER -- requirements
Module: trace_serializer

---
 rtl/trace_pkg.sv | 51 +++++
 rtl/trace_fifo.sv | 47 ++++
 rtl/trace_serializer.sv | 100 ++++++++++
 tb/tb_trace_serializer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared record layout, FSM states and the byte-selection helper
// used by the trace serializer and its record FIFO.
package trace_pkg;

    localparam int RECORD_BYTES = 13;
    localparam int PC_W         = 32;
    localparam int INST_W       = 32;
    localparam int WADDR_W      = 5;
    localparam int WDATA_W      = 32;
    localparam int IDX_W        = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_BYTES - 1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INST_W-1:0]  inst;
        logic               we;
        logic [WADDR_W-1:0] waddr;
        logic [WDATA_W-1:0] wdata;
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

    // Wire order: pc, inst, header {we, 00, waddr}, wdata; MSB first per field.
    function automatic logic [7:0] rec_byte(input trace_rec_t r, input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = r.pc[31:24];
            4'd1:    b = r.pc[23:16];
            4'd2:    b = r.pc[15:8];
            4'd3:    b = r.pc[7:0];
            4'd4:    b = r.inst[31:24];
            4'd5:    b = r.inst[23:16];
            4'd6:    b = r.inst[15:8];
            4'd7:    b = r.inst[7:0];
            4'd8:    b = {r.we, 2'b00, r.waddr};
            4'd9:    b = r.wdata[31:24];
            4'd10:   b = r.wdata[23:16];
            4'd11:   b = r.wdata[15:8];
            4'd12:   b = r.wdata[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO; pointers carry one extra wrap bit so that
// full and empty can be told apart. Head data is read combinationally.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [REC_W-1:0] wdata,
    input  logic             pop,
    output logic [REC_W-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, a simultaneous pop frees the head slot that the push overwrites.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/trace_serializer.sv
// Captures committed-instruction trace records into a FIFO and streams each
// as 13 bytes over a valid/ready byte port; counts records lost to a full FIFO.
//   state   | meaning
//   ST_IDLE | FIFO empty, nothing to send
//   ST_SEND | streaming the head record, byte_idx selects the byte
module trace_serializer
    import trace_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trace_valid,
    input  logic [31:0]      trace_pc,
    input  logic [31:0]      trace_inst,
    input  logic             rf_we,
    input  logic [4:0]       rf_waddr,
    input  logic [31:0]      rf_wdata,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count
);

    ser_state_t       state;
    ser_state_t       next_state;
    logic [IDX_W-1:0] byte_idx;
    trace_rec_t       in_rec;
    trace_rec_t       head_rec;
    logic [REC_W-1:0] head_bits;
    logic             fifo_full;
    logic             fifo_empty;
    logic             xfer;
    logic             last_xfer;
    logic             push;
    logic             drop;

    assign in_rec    = '{pc: trace_pc, inst: trace_inst, we: rf_we,
                         waddr: rf_waddr, wdata: rf_wdata};
    assign head_rec  = trace_rec_t'(head_bits);
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (byte_idx == LAST_IDX);
    assign push      = trace_valid && (!fifo_full || last_xfer);
    assign drop      = trace_valid && !push;
    assign out_data  = out_valid ? rec_byte(head_rec, byte_idx) : 8'h00;

    trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (in_rec),
        .pop   (last_xfer),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            byte_idx <= '0;
        end else begin
            state <= next_state;
            if (xfer) byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 4'd1;
        end
    end

    // out_valid follows FIFO occupancy directly so the first byte appears one
    // cycle after capture and records chain without a bubble.
    always_comb begin
        next_state = state;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                out_valid = !fifo_empty;
                if (!fifo_empty) next_state = ST_SEND;
            end
            ST_SEND: begin
                out_valid = !fifo_empty;
                if (fifo_empty) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != {CNT_W{1'b1}}) drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_trace_serializer.sv
// Directed bench for trace_serializer: byte stream order, backpressure,
// overflow/drop counting, full-plus-pop acceptance, reset and saturation.
module tb_trace_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_inst;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        overflow;
    logic [15:0] drop_count;

    int total  = 0;
    int passed = 0;
    int steps  = 0;
    logic [7:0] rx [$];

    trace_serializer #(
        .FIFO_DEPTH (8),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trace_valid (trace_valid),
        .trace_pc    (trace_pc),
        .trace_inst  (trace_inst),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_byte(input logic [31:0] pc, input logic [31:0] inst,
                                            input logic we, input logic [4:0] wa,
                                            input logic [31:0] wd, input int idx);
        logic [103:0] flat;
        flat = {pc, inst, we, 2'b00, wa, wd};
        return flat[103 - 8*idx -: 8];
    endfunction

    function automatic logic [31:0] rpc(input int k);  return 32'h0000_1000 + 32'(k) * 4; endfunction
    function automatic logic [31:0] rinst(input int k); return 32'hA500_0000 | 32'(k); endfunction
    function automatic logic        rwe(input int k);   return k[0]; endfunction
    function automatic logic [4:0]  rwa(input int k);   return k[4:0]; endfunction
    function automatic logic [31:0] rwd(input int k);   return 32'hD000_0000 + 32'(k) * 32'h0101; endfunction

    function automatic logic [7:0] gen_byte(input int k, input int idx);
        return exp_byte(rpc(k), rinst(k), rwe(k), rwa(k), rwd(k), idx);
    endfunction

    task automatic step();
        if (out_valid && out_ready) rx.push_back(out_data);
        @(posedge clk);
        #1;
        steps++;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        trace_valid = 1'b1;
        trace_pc    = pc;
        trace_inst  = inst;
        rf_we       = we;
        rf_waddr    = wa;
        rf_wdata    = wd;
        step();
        trace_valid = 1'b0;
    endtask

    task automatic drive_k(input int k);
        drive(rpc(k), rinst(k), rwe(k), rwa(k), rwd(k));
    endtask

    task automatic receive(input int n, input int budget);
        int c = 0;
        while (rx.size() < n && c < budget) begin
            step();
            c++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0)    $display("FAIL rst_out_valid got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 8'h00)    $display("FAIL rst_out_data got %h want 00", out_data); else passed++;
        total++; if (overflow !== 1'b0)     $display("FAIL rst_overflow got %b want 0", overflow); else passed++;
        total++; if (drop_count !== 16'h0)  $display("FAIL rst_drop_count got %h want 0000", drop_count); else passed++;
        drive_k(99);
        total++; if (out_valid !== 1'b0)    $display("FAIL rst_capture got out_valid %b want 0", out_valid); else passed++;
        reset = 1'b1;
        step();
        total++; if (out_valid !== 1'b0)    $display("FAIL rst_release got out_valid %b want 0", out_valid); else passed++;
    endtask

    task automatic test_single();
        logic [7:0] ref_b [13];
        int errs = 0;
        ref_b = '{8'h00, 8'h40, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h00, 8'h00,
                  8'h81, 8'h10, 8'h01, 8'h00, 8'h00};
        rx.delete();
        out_ready = 1'b1;
        drive(32'h0040_0000, 32'h3C01_0000, 1'b1, 5'd1, 32'h1001_0000);
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h00)
            $display("FAIL single_latency got valid %b data %h want valid 1 data 00", out_valid, out_data);
        else passed++;
        steps = 0;
        receive(13, 13);
        total++; if (steps != 13) $display("FAIL single_cycles got %0d want 13", steps); else passed++;
        for (int i = 0; i < rx.size() && i < 13; i++) if (rx[i] !== ref_b[i]) errs++;
        total++;
        if (errs != 0 || rx.size() != 13)
            $display("FAIL single_stream got %0d bytes %0d wrong want 13 bytes 0 wrong", rx.size(), errs);
        else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL single_idle got out_valid %b want 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back();
        int errs = 0;
        rx.delete();
        out_ready = 1'b1;
        drive_k(20);
        drive_k(21);
        steps = 0;
        receive(26, 40);
        total++; if (steps != 25) $display("FAIL b2b_cycles got %0d want 25", steps); else passed++;
        for (int i = 0; i < rx.size() && i < 26; i++) if (rx[i] !== gen_byte(20 + i / 13, i % 13)) errs++;
        total++;
        if (errs != 0 || rx.size() != 26)
            $display("FAIL b2b_stream got %0d bytes %0d wrong want 26 bytes 0 wrong", rx.size(), errs);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [7:0] ref_b [13];
        int errs = 0;
        ref_b = '{8'h00, 8'h40, 8'h00, 8'h00, 8'h3C, 8'h01, 8'h00, 8'h00,
                  8'h81, 8'h10, 8'h01, 8'h00, 8'h00};
        rx.delete();
        out_ready = 1'b1;
        drive(32'h0040_0000, 32'h3C01_0000, 1'b1, 5'd1, 32'h1001_0000);
        receive(4, 10);
        out_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'h3C)
                $display("FAIL bp_hold%0d got valid %b data %h want valid 1 data 3c", s, out_valid, out_data);
            else passed++;
            step();
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C)
            $display("FAIL bp_hold2 got valid %b data %h want valid 1 data 3c", out_valid, out_data);
        else passed++;
        out_ready = 1'b1;
        receive(13, 20);
        for (int i = 0; i < rx.size() && i < 13; i++) if (rx[i] !== ref_b[i]) errs++;
        total++;
        if (errs != 0 || rx.size() != 13)
            $display("FAIL bp_stream got %0d bytes %0d wrong want 13 bytes 0 wrong", rx.size(), errs);
        else passed++;
    endtask

    task automatic test_overflow();
        int errs = 0;
        rx.delete();
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) drive_k(k);
        total++; if (overflow !== 1'b1)       $display("FAIL ovf_flag got %b want 1", overflow); else passed++;
        total++; if (drop_count !== 16'd2)    $display("FAIL ovf_count got %0d want 2", drop_count); else passed++;
        out_ready = 1'b1;
        receive(104, 150);
        for (int i = 0; i < rx.size() && i < 104; i++) if (rx[i] !== gen_byte(i / 13, i % 13)) errs++;
        total++;
        if (errs != 0 || rx.size() != 104)
            $display("FAIL ovf_stream got %0d bytes %0d wrong want 104 bytes 0 wrong", rx.size(), errs);
        else passed++;
        step();
        step();
        total++;
        if (out_valid !== 1'b0 || rx.size() != 104)
            $display("FAIL ovf_drained got valid %b bytes %0d want valid 0 bytes 104", out_valid, rx.size());
        else passed++;
    endtask

    task automatic test_full_plus_pop();
        int errs = 0;
        rx.delete();
        out_ready = 1'b0;
        for (int k = 30; k < 38; k++) drive_k(k);
        total++; if (drop_count !== 16'd2) $display("FAIL fpp_fill_count got %0d want 2", drop_count); else passed++;
        out_ready = 1'b1;
        receive(12, 12);
        total++; if (rx.size() != 12) $display("FAIL fpp_pre_bytes got %0d want 12", rx.size()); else passed++;
        drive_k(38);
        total++; if (drop_count !== 16'd2) $display("FAIL fpp_count got %0d want 2", drop_count); else passed++;
        receive(117, 200);
        for (int i = 0; i < rx.size() && i < 117; i++) if (rx[i] !== gen_byte(30 + i / 13, i % 13)) errs++;
        total++;
        if (errs != 0 || rx.size() != 117)
            $display("FAIL fpp_stream got %0d bytes %0d wrong want 117 bytes 0 wrong", rx.size(), errs);
        else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL fpp_sticky got %b want 1", overflow); else passed++;
    endtask

    task automatic test_reset_mid();
        int errs = 0;
        rx.delete();
        out_ready = 1'b1;
        drive_k(40);
        receive(6, 10);
        total++;
        if (out_valid !== 1'b1 || out_data !== gen_byte(40, 6))
            $display("FAIL rmid_byte6 got valid %b data %h want valid 1 data %h", out_valid, out_data, gen_byte(40, 6));
        else passed++;
        reset = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0)   $display("FAIL rmid_valid got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 8'h00)   $display("FAIL rmid_data got %h want 00", out_data); else passed++;
        total++; if (overflow !== 1'b0)    $display("FAIL rmid_overflow got %b want 0", overflow); else passed++;
        total++; if (drop_count !== 16'h0) $display("FAIL rmid_count got %0d want 0", drop_count); else passed++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL rmid_after got out_valid %b want 0", out_valid); else passed++;
        rx.delete();
        drive_k(41);
        receive(13, 20);
        for (int i = 0; i < rx.size() && i < 13; i++) if (rx[i] !== gen_byte(41, i)) errs++;
        total++;
        if (errs != 0 || rx.size() != 13)
            $display("FAIL rmid_stream got %0d bytes %0d wrong want 13 bytes 0 wrong", rx.size(), errs);
        else passed++;
    endtask

    task automatic test_saturation();
        out_ready   = 1'b0;
        trace_valid = 1'b1;
        trace_pc    = rpc(50);
        trace_inst  = rinst(50);
        rf_we       = rwe(50);
        rf_waddr    = rwa(50);
        rf_wdata    = rwd(50);
        repeat (8) step();
        total++; if (drop_count !== 16'd0) $display("FAIL sat_fill got %0d want 0", drop_count); else passed++;
        repeat (65534) step();
        total++; if (drop_count !== 16'hFFFE) $display("FAIL sat_fffe got %h want fffe", drop_count); else passed++;
        step();
        total++; if (drop_count !== 16'hFFFF) $display("FAIL sat_ffff got %h want ffff", drop_count); else passed++;
        repeat (4) step();
        trace_valid = 1'b0;
        total++;
        if (drop_count !== 16'hFFFF || overflow !== 1'b1)
            $display("FAIL sat_hold got count %h overflow %b want ffff 1", drop_count, overflow);
        else passed++;
    endtask

    initial begin
        trace_valid = 1'b0;
        trace_pc    = '0;
        trace_inst  = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        out_ready   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_full_plus_pop();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
